// File: rtl/dino_game_ctrl.sv
// Dino game controller: button sync, jump/ground FSM, collision check, saturating score.
// Optional high-score register is enabled by defining HISCORE_EN.
module dino_game_ctrl #(
    parameter int DINO_COL   = 6,
    parameter int JUMP_TICKS = 3,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               jump_btn,
    input  logic [7:0]         obs_row,
    output logic               run_tick,
    output logic [7:0]         ground_row,
    output logic [7:0]         up_row,
    output logic               playing,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GROUND = 2'd1,
        AIR    = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam logic [7:0]         DINO_MASK = 8'(1 << DINO_COL);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             state;
    state_t             state_nxt;
    logic               s1, s2, s3;
    logic               jump_p;
    logic               jump_req;
    logic [3:0]         air_cnt;
    logic               collision;
    logic               jump_go;
    logic [SCORE_W-1:0] score_inc;

    assign jump_p    = s2 & ~s3;
    assign collision = obs_row[DINO_COL];
    assign jump_go   = jump_req | jump_p;
    assign score_inc = (score == SCORE_MAX) ? score : score + SCORE_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state_nxt gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (jump_p) state_nxt = GROUND;
            GROUND: if (tick) begin
                        if (collision)    state_nxt = OVER;
                        else if (jump_go) state_nxt = AIR;
                    end
            AIR:    if (tick && air_cnt == 4'd1) state_nxt = GROUND;
            OVER:   if (jump_p) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        playing    = (state == GROUND) || (state == AIR);
        game_over  = (state == OVER);
        run_tick   = tick & playing;
        up_row     = (state == AIR) ? DINO_MASK : 8'h00;
        ground_row = (state == AIR) ? obs_row : (obs_row | DINO_MASK);
    end

    // Button synchroniser, score, jump timer and pending-jump flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            score    <= '0;
            air_cnt  <= '0;
            jump_req <= 1'b0;
        end else begin
            s1 <= jump_btn;
            s2 <= s1;
            s3 <= s2;
            jump_req <= 1'b0;
            unique case (state)
                IDLE: if (jump_p) score <= '0;
                GROUND: begin
                    if (tick) begin
                        if (!collision) begin
                            score <= score_inc;
                            if (jump_go) air_cnt <= 4'(JUMP_TICKS);
                        end
                    end else begin
                        jump_req <= jump_req | jump_p;
                    end
                end
                AIR: if (tick) begin
                    score   <= score_inc;
                    air_cnt <= air_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef HISCORE_EN
    // The score is final on the tick that moves GROUND to OVER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hi_score <= '0;
        else if (state == GROUND && tick && collision && score > hi_score)
            hi_score <= score;
    end
`else
    assign hi_score = '0;
`endif

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed bench for dino_game_ctrl: an 8-bit-score instance plus a 4-bit-score instance on shared inputs.
// Expected values are queued on a scoreboard as stimulus is applied and popped when outputs are sampled.
module tb_dino_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       jump_btn;
    logic [7:0] obs_row;

    logic       run_tick, playing, game_over;
    logic [7:0] ground_row, up_row, score, hi_score;
    logic       run_tick4, playing4, game_over4;
    logic [7:0] ground_row4, up_row4;
    logic [3:0] score4, hi_score4;

    always #5 clk = ~clk;

    dino_game_ctrl #(.DINO_COL(6), .JUMP_TICKS(3), .SCORE_W(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .jump_btn(jump_btn), .obs_row(obs_row),
        .run_tick(run_tick), .ground_row(ground_row), .up_row(up_row), .playing(playing),
        .game_over(game_over), .score(score), .hi_score(hi_score)
    );

    dino_game_ctrl #(.DINO_COL(6), .JUMP_TICKS(3), .SCORE_W(4)) dut4 (
        .clk(clk), .reset(reset), .tick(tick), .jump_btn(jump_btn), .obs_row(obs_row),
        .run_tick(run_tick4), .ground_row(ground_row4), .up_row(up_row4), .playing(playing4),
        .game_over(game_over4), .score(score4), .hi_score(hi_score4)
    );

`ifdef HISCORE_EN
    localparam int HI_EXP = 15;
`else
    localparam int HI_EXP = 0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   rt_count   = 0;
    int   rt_bad     = 0;
    int   rt_snap;

    // run_tick monitor, sampled 1 ns before each rising edge.
    always @(negedge clk) begin
        #4;
        if (run_tick === 1'b1) rt_count++;
        if (run_tick === 1'b1 && tick !== 1'b1) rt_bad++;
    end

    function automatic void push(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endfunction

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL sb_empty: observed %0h, no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                mismatched++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic press();
        jump_btn = 1'b1;
        cyc(4);
        jump_btn = 1'b0;
        cyc(4);
    endtask

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        jump_btn = 1'b0;
        obs_row  = 8'h00;
        cyc(2);

        // Reset state
        push("rst_playing", 0);    push("rst_game_over", 0); push("rst_score", 0);
        push("rst_up_row", 0);     push("rst_ground_row", 32'h40);
        push("rst_run_tick", 0);   push("rst_hi_score", 0);
        chk(playing); chk(game_over); chk(score); chk(up_row); chk(ground_row);
        chk(run_tick); chk(hi_score);
        reset = 1'b0;
        cyc(1);

        // Start: playing rises only at the third edge after the button rise
        jump_btn = 1'b1;
        push("t1_edge2_idle", 0); push("t1_edge3_play", 1);
        push("t1_score", 0);      push("t1_ground_row", 32'h40);
        cyc(2); chk(playing);
        cyc(1); chk(playing); chk(score); chk(ground_row);
        jump_btn = 1'b0;
        cyc(4);

        // Ten obstacle-free ticks
        rt_count = 0;
        push("t2_score", 10); push("t2_score4", 10); push("t2_rt_count", 10); push("t2_rt_bad", 0);
        repeat (10) do_tick();
        chk(score); chk(score4); chk(rt_count); chk(rt_bad);

        // Jump request between ticks, taken on the next tick
        push("t4_pre_up_row", 0); push("t4_pre_playing", 1);
        press();
        chk(up_row); chk(playing);
        push("t4_air_up_row", 32'h40); push("t4_air_ground_row", 32'h05); push("t4_air_score", 11);
        obs_row = 8'h00;
        do_tick();
        obs_row = 8'h05;
        cyc(1);
        chk(up_row); chk(ground_row); chk(score);
        press();                    // discarded while airborne
        obs_row = 8'h40;
        push("t4_air2_score", 13); push("t4_air2_game_over", 0); push("t4_air2_up_row", 32'h40);
        do_tick(); do_tick();
        chk(score); chk(game_over); chk(up_row);
        push("t4_land_score", 14); push("t4_land_up_row", 0); push("t4_land_playing", 1);
        do_tick();
        chk(score); chk(up_row); chk(playing);
        obs_row = 8'h00;
        push("t4_nobuf_up_row", 0); push("t4_nobuf_score", 15);
        do_tick();
        chk(up_row); chk(score);

        // Collision ends the game; later ticks are not forwarded
        obs_row = 8'h40;
        rt_snap = rt_count;
        push("t3_game_over", 1); push("t3_playing", 0); push("t3_score", 15);
        do_tick();
        chk(game_over); chk(playing); chk(score);
        obs_row = 8'h00;
        push("t3_rt_count", rt_snap + 1); push("t3_score_hold", 15);
        push("t3_over_ground_row", 32'h40); push("t3_hi_a", HI_EXP);
        do_tick(); do_tick(); do_tick();
        chk(rt_count); chk(score); chk(ground_row); chk(hi_score);

        // Restart and play a shorter game B
        push("t6_idle_game_over", 0); push("t6_idle_playing", 0);
        press();
        chk(game_over); chk(playing);
        push("t6_start_score", 0); push("t6_start_playing", 1);
        press();
        chk(score); chk(playing);
        repeat (3) do_tick();
        obs_row = 8'h40;
        push("t6_b_score", 3); push("t6_b_over", 1); push("t6_hi_b", HI_EXP);
        do_tick();
        chk(score); chk(game_over); chk(hi_score);

        // Saturation and reset while airborne
        obs_row = 8'h00;
        press(); press();
        push("t5_score", 20); push("t5_score4_sat", 15);
        repeat (20) do_tick();
        chk(score); chk(score4);
        press();
        push("t5_air_up_row", 32'h40); push("t5_air_score", 21);
        do_tick();
        chk(up_row); chk(score);
        #2 reset = 1'b1;
        #1;
        push("t5_rst_playing", 0); push("t5_rst_score", 0); push("t5_rst_score4", 0);
        push("t5_rst_up_row", 0);  push("t5_rst_hi", 0);    push("t5_rst_ground_row", 32'h40);
        chk(playing); chk(score); chk(score4); chk(up_row); chk(hi_score); chk(ground_row);
        @(negedge clk);
        reset = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
